alu_rmw_sequencer: RTL and testbench
====================================

// Module: alu_rmw_sequencer
// PURPOSE
//  Sequences the 6502 ALU for accumulator ops and memory read-modify-write (RMW) ops.
//  Accepts one op per request handshake, registers the operands and drives the ALU's func/operand/carry/D inputs.
//  Runs the NMOS RMW bus pattern: read, dummy write of the original value, final write.
//  Captures the ALU result and the flags that op may change, then returns them to the CPU core.
// PARAMETERS
//  WAIT_MAX   15   max mem_rdy wait cycles per access before mem_err; 0 disables the timeout
// PORTS
//  clk           in   1  system clock, rising edge
//  nRESET        in   1  asynchronous, active-low reset
//  req_valid     in   1  op request
//  req_ready     out  1  high in IDLE only
//  req_func      in   4  ALU function code (shared ALU function defines)
//  req_rmw       in   1  1 = memory RMW op, 0 = register op
//  req_a         in   8  SB operand (accumulator/index value)
//  req_b         in   8  B operand (register ops only)
//  req_addr      in  16  RMW effective address
//  p_in          in   8  current P register (C=bit0, Z=1, D=3, V=6, N=7)
//  alu_func      out  4  to ALU_FUNC
//  alu_sb        out  8  to SB
//  alu_b         out  8  to ALU_B
//  alu_cin       out  1  to CARRY_IN
//  alu_d         out  1  to D_flag
//  alu_out       in   8  from ALU_out
//  alu_c/v/n/z   in   1  from ALU_COUT/VOUT/NOUT/ZOUT (4 ports)
//  mem_addr      out 16  bus address
//  mem_wdata     out  8  bus write data
//  mem_rd        out  1  read strobe, held until mem_rdy
//  mem_wr        out  1  write strobe, held until mem_rdy
//  mem_rdata     in   8  read data, valid with mem_rdy
//  mem_rdy       in   1  access complete (1 MHz bus stretch)
//  mem_err       out  1  one-cycle pulse on wait timeout
//  done          out  1  one-cycle pulse: result and p_out valid
//  result        out  8  ALU result, held until the next done
//  p_out         out  8  updated P register, held until the next done
// BEHAVIOUR
//  Reset (async, nRESET=0): state IDLE; every output 0 except req_ready=1.
//  States: IDLE, EXEC, RD, DUMMY, WR, DONE.
//  IDLE: req_valid & req_ready latches all req_* and p_in.
//    Next state is EXEC if req_rmw=0, otherwise RD. req_* are ignored outside IDLE.
//  EXEC: drives the ALU with the latched a/b, func, cin=P.C and d=P.D.
//    Captures alu_out and the flags at the end of the cycle. Next: DONE.
//  RD: mem_rd=1 at req_addr. On mem_rdy: latch mem_rdata as operand B, go to DUMMY.
//  DUMMY: mem_wr=1 with the original value. ALU is driven combinationally in this state.
//    On mem_rdy: capture result and flags, go to WR.
//  WR: mem_wr=1 with the captured result. On mem_rdy: go to DONE.
//  DONE: done=1 for one cycle, then IDLE. req_ready=1 again in that following cycle.
//  Latency: register op, done 2 cycles after accept.
//    RMW op with zero wait states, done 4 cycles after accept; each wait cycle adds 1.
//  Flag update mask (bits not listed keep their p_in value):
//    ADD/SUB: N V Z C.  AND/ORA/EOR/PASS: N Z.  INC/DEC: N Z only; alu_c is discarded.
//    ASL/LSR/ROL/ROR: N Z C.  D, I, B and bit5 are never modified.
//  Decimal-mode N/V/Z are taken from the ALU unchanged (NMOS-faithful); the sequencer does no correction.
//  RMW ops force alu_d=0. The ALU treats D=1 with a non-ADD function as SUB adjust, so D must be 0 here.
//  alu_sb=0 during RMW. alu_func is held constant from accept until DONE.
//  Wait timeout: a counter (log2(WAIT_MAX+1) bits) clears on entering each bus state.
//    If it reaches WAIT_MAX without mem_rdy: pulse mem_err, drop the strobes, go IDLE.
//    No done is issued; result and p_out are unchanged.
//  If mem_rdy arrives in the same cycle the counter reaches WAIT_MAX, mem_rdy wins.
//  mem_rdy seen outside RD/DUMMY/WR is ignored.
//  Async reset mid-RMW drops the strobes immediately; the partial write is abandoned.
// STRUCTURE
//  Shared header: ALU function code defines (shared with the ALU), P bit-index constants, state encodings.
//  One sub-module: alu_flag_merge.
//    Combinational; inputs func, p, and alu c/v/n/z; output is the new P per the mask above.
//  The FSM, wait counter and latches stay in this module. The ALU itself is instantiated by the parent.
// TESTING
//  1. Reg ADD, a=0x50, b=0x50, P=0x00 -> result 0x A0 without space: 0xA0; p_out=0xC0 (N,V); done 2 cycles after accept.
//  2. RMW INC at 0x0070, mem=0xFF, P.C=0 -> rd, wr 0xFF, wr 0x00; p_out Z=1, C=0 (INC/DEC never touch C).
//  3. RMW ROL, mem=0x80, P.C=1, P.D=1 -> alu_d=0; write 0x01; C=1, N=0, Z=0.
//  4. Decimal SUB, a=0x10, b=0x01, P=0x09 (D,C) -> result 0x09, C=1.
//  5. mem_rdy low for WAIT_MAX cycles in RD -> mem_err pulse, no done, req_ready=1 the next cycle.
//     Repeat with mem_rdy arriving on the same cycle the counter hits WAIT_MAX -> access completes, no mem_err.
//  6. nRESET low during DUMMY with mem_wr=1 -> mem_wr=0 at once; after release, a reg op completes normally.

Source files
------------

// File: rtl/alu_rmw_sequencer_pkg.sv
// rtl/alu_rmw_sequencer_pkg.sv - ALU function codes, P bit indices, sequencer states and flag masks
package alu_rmw_sequencer_pkg;

  // Function codes shared with the ALU
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_ORA  = 4'h3;
  localparam logic [3:0] ALU_EOR  = 4'h4;
  localparam logic [3:0] ALU_PASS = 4'h5;
  localparam logic [3:0] ALU_INC  = 4'h6;
  localparam logic [3:0] ALU_DEC  = 4'h7;
  localparam logic [3:0] ALU_ASL  = 4'h8;
  localparam logic [3:0] ALU_LSR  = 4'h9;
  localparam logic [3:0] ALU_ROL  = 4'hA;
  localparam logic [3:0] ALU_ROR  = 4'hB;

  localparam logic [2:0] P_C = 3'd0;
  localparam logic [2:0] P_Z = 3'd1;
  localparam logic [2:0] P_I = 3'd2;
  localparam logic [2:0] P_D = 3'd3;
  localparam logic [2:0] P_B = 3'd4;
  localparam logic [2:0] P_V = 3'd6;
  localparam logic [2:0] P_N = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_RD    = 3'd2,
    ST_DUMMY = 3'd3,
    ST_WR    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } flag_mask_t;

  // INC/DEC deliberately leave C alone even though the ALU produces a carry
  function automatic flag_mask_t flag_mask(input logic [3:0] func);
    flag_mask_t m;
    m = '0;
    case (func)
      ALU_ADD, ALU_SUB:                    m = 4'b1111;
      ALU_AND, ALU_ORA, ALU_EOR, ALU_PASS,
      ALU_INC, ALU_DEC:                    m = 4'b1010;
      ALU_ASL, ALU_LSR, ALU_ROL, ALU_ROR:  m = 4'b1011;
      default:                             m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_rmw_sequencer_if.sv
// rtl/alu_rmw_sequencer_if.sv - op request/response handshake and memory bus of the RMW sequencer
interface alu_rmw_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_func;
  logic        req_rmw;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [15:0] req_addr;
  logic [7:0]  p_in;
  logic        done;
  logic [7:0]  result;
  logic [7:0]  p_out;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_rdy;
  logic        mem_err;

  // master: CPU core plus memory side; slave: the sequencer
  modport master (
    output req_valid, req_func, req_rmw, req_a, req_b, req_addr, p_in,
    output mem_rdata, mem_rdy,
    input  req_ready, done, result, p_out,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_err
  );

  modport slave (
    input  req_valid, req_func, req_rmw, req_a, req_b, req_addr, p_in,
    input  mem_rdata, mem_rdy,
    output req_ready, done, result, p_out,
    output mem_addr, mem_wdata, mem_rd, mem_wr, mem_err
  );
endinterface

// File: rtl/alu_flag_merge.sv
// rtl/alu_flag_merge.sv - merges ALU flag outputs into P according to the per-function update mask
module alu_flag_merge
  import alu_rmw_sequencer_pkg::*;
(
  input  logic [3:0] func,
  input  logic [7:0] p,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_n,
  input  logic       alu_z,
  output logic [7:0] p_new
);

  flag_mask_t m;

  always_comb begin
    m     = flag_mask(func);
    p_new = p;
    if (m.n) p_new[P_N] = alu_n;
    if (m.v) p_new[P_V] = alu_v;
    if (m.z) p_new[P_Z] = alu_z;
    if (m.c) p_new[P_C] = alu_c;
  end

endmodule

// File: rtl/alu_rmw_sequencer.sv
// rtl/alu_rmw_sequencer.sv - sequences the 6502 ALU for register ops and NMOS read/dummy-write/write RMW ops
module alu_rmw_sequencer
  import alu_rmw_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                nRESET,
  alu_rmw_sequencer_if.slave  bus,
  output logic [3:0]          alu_func,
  output logic [7:0]          alu_sb,
  output logic [7:0]          alu_b,
  output logic                alu_cin,
  output logic                alu_d,
  input  logic [7:0]          alu_out,
  input  logic                alu_c,
  input  logic                alu_v,
  input  logic                alu_n,
  input  logic                alu_z
);

  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    p_q;
  logic [7:0]    p_cap;
  logic [7:0]    res_q;
  logic [7:0]    p_new;
  logic          timeout;

  assign timeout = (WAIT_MAX != 0) && (wait_cnt == WAIT_LIM);

  alu_flag_merge u_flag_merge (
    .func  (alu_func),
    .p     (p_q),
    .alu_c (alu_c),
    .alu_v (alu_v),
    .alu_n (alu_n),
    .alu_z (alu_z),
    .p_new (p_new)
  );

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      p_q           <= '0;
      p_cap         <= '0;
      res_q         <= '0;
      alu_func      <= '0;
      alu_sb        <= '0;
      alu_b         <= '0;
      alu_cin       <= 1'b0;
      alu_d         <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.p_out     <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_err   <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            alu_func      <= bus.req_func;
            alu_cin       <= bus.p_in[P_C];
            p_q           <= bus.p_in;
            bus.mem_addr  <= bus.req_addr;
            if (bus.req_rmw) begin
              // D must be 0 here: the ALU would apply a decimal SUB adjust to shifts/INC/DEC
              alu_sb     <= '0;
              alu_b      <= '0;
              alu_d      <= 1'b0;
              bus.mem_rd <= 1'b1;
              wait_cnt   <= '0;
              state      <= ST_RD;
            end else begin
              alu_sb <= bus.req_a;
              alu_b  <= bus.req_b;
              alu_d  <= bus.p_in[P_D];
              state  <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          bus.result <= alu_out;
          bus.p_out  <= p_new;
          bus.done   <= 1'b1;
          state      <= ST_DONE;
        end

        ST_RD: begin
          if (bus.mem_rdy) begin
            alu_b         <= bus.mem_rdata;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b1;
            bus.mem_wdata <= bus.mem_rdata;
            wait_cnt      <= '0;
            state         <= ST_DUMMY;
          end else if (timeout) begin
            bus.mem_rd    <= 1'b0;
            bus.mem_err   <= 1'b1;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // The ALU works on the read value while the original byte is written back
        ST_DUMMY: begin
          if (bus.mem_rdy) begin
            res_q         <= alu_out;
            p_cap         <= p_new;
            bus.mem_wdata <= alu_out;
            wait_cnt      <= '0;
            state         <= ST_WR;
          end else if (timeout) begin
            bus.mem_wr    <= 1'b0;
            bus.mem_err   <= 1'b1;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_WR: begin
          if (bus.mem_rdy) begin
            bus.mem_wr <= 1'b0;
            bus.result <= res_q;
            bus.p_out  <= p_cap;
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end else if (timeout) begin
            bus.mem_wr    <= 1'b0;
            bus.mem_err   <= 1'b1;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end

        default: begin
          bus.mem_rd    <= 1'b0;
          bus.mem_wr    <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// tb/tb_alu_rmw_sequencer.sv - directed self-checking bench for alu_rmw_sequencer with ALU and memory models
module tb_alu_rmw_sequencer;
  import alu_rmw_sequencer_pkg::*;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        nRESET;
  logic [3:0]  alu_func;
  logic [7:0]  alu_sb, alu_b, alu_out;
  logic        alu_cin, alu_d, alu_c, alu_v, alu_n, alu_z;
  logic [8:0]  s9;
  logic [4:0]  lo5;
  logic [7:0]  bin;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  mem [256];
  int          ws_cfg = 0;
  int          ws_left = 0;
  int          n_wr = 0;
  logic [15:0] wr_addr [8];
  logic [7:0]  wr_data [8];
  logic [15:0] rd_addr;
  logic        d_in_bus;

  alu_rmw_sequencer_if bus ();

  alu_rmw_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk      (clk),
    .nRESET   (nRESET),
    .bus      (bus),
    .alu_func (alu_func),
    .alu_sb   (alu_sb),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_d    (alu_d),
    .alu_out  (alu_out),
    .alu_c    (alu_c),
    .alu_v    (alu_v),
    .alu_n    (alu_n),
    .alu_z    (alu_z)
  );

  always #5 clk = ~clk;

  // Reference 6502 ALU: N/Z come from the binary result, decimal adjust only on SUB
  always_comb begin
    s9    = '0;
    lo5   = '0;
    bin   = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_func)
      ALU_ADD: begin
        s9    = {1'b0, alu_sb} + {1'b0, alu_b} + {8'b0, alu_cin};
        bin   = s9[7:0];
        alu_c = s9[8];
        alu_v = (alu_sb[7] == alu_b[7]) && (bin[7] != alu_sb[7]);
      end
      ALU_SUB: begin
        s9    = {1'b0, alu_sb} - {1'b0, alu_b} - {8'b0, ~alu_cin};
        lo5   = {1'b0, alu_sb[3:0]} - {1'b0, alu_b[3:0]} - {4'b0, ~alu_cin};
        bin   = s9[7:0];
        alu_c = ~s9[8];
        alu_v = (alu_sb[7] != alu_b[7]) && (bin[7] != alu_sb[7]);
      end
      ALU_AND:  bin = alu_sb & alu_b;
      ALU_ORA:  bin = alu_sb | alu_b;
      ALU_EOR:  bin = alu_sb ^ alu_b;
      ALU_PASS: bin = alu_b;
      ALU_INC:  begin bin = alu_b + 8'd1; alu_c = (alu_b == 8'hFF); end
      ALU_DEC:  begin bin = alu_b - 8'd1; alu_c = (alu_b != 8'h00); end
      ALU_ASL:  begin bin = {alu_b[6:0], 1'b0};    alu_c = alu_b[7]; end
      ALU_LSR:  begin bin = {1'b0, alu_b[7:1]};    alu_c = alu_b[0]; end
      ALU_ROL:  begin bin = {alu_b[6:0], alu_cin}; alu_c = alu_b[7]; end
      ALU_ROR:  begin bin = {alu_cin, alu_b[7:1]}; alu_c = alu_b[0]; end
      default:  bin = 8'h00;
    endcase
    alu_n   = bin[7];
    alu_z   = (bin == 8'h00);
    alu_out = bin;
    if (alu_func == ALU_SUB && alu_d) begin
      if (lo5[4]) alu_out = alu_out - 8'h06;
      if (s9[8])  alu_out = alu_out - 8'h60;
    end
  end

  // Memory: answers each strobe after ws_cfg wait cycles and logs completed writes
  always @(negedge clk) begin
    if ((bus.mem_rd || bus.mem_wr) && alu_d) d_in_bus = 1'b1;
    if (bus.mem_rd || bus.mem_wr) begin
      if (ws_left == 0) begin
        bus.mem_rdy = 1'b1;
        ws_left     = ws_cfg;
        if (bus.mem_rd) begin
          bus.mem_rdata = mem[bus.mem_addr[7:0]];
          rd_addr       = bus.mem_addr;
        end else begin
          mem[bus.mem_addr[7:0]] = bus.mem_wdata;
          if (n_wr < 8) begin
            wr_addr[n_wr] = bus.mem_addr;
            wr_data[n_wr] = bus.mem_wdata;
          end
          n_wr++;
        end
      end else begin
        bus.mem_rdy = 1'b0;
        ws_left--;
      end
    end else begin
      bus.mem_rdy = 1'b0;
      ws_left     = ws_cfg;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one op; lat counts cycles from the accept cycle to done or mem_err
  task automatic run_op(input logic [3:0] f, input logic rmw, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] addr, input logic [7:0] p, input int ws,
                        output int lat, output logic err, output logic [3:0] func_end, output logic d_c1);
    ws_cfg   = ws;
    n_wr     = 0;
    d_in_bus = 1'b0;
    @(negedge clk);
    check_eq("ready_in_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_func  = f;
    bus.req_rmw   = rmw;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_addr  = addr;
    bus.p_in      = p;
    @(negedge clk);
    bus.req_func  = ~f;
    bus.req_rmw   = ~rmw;
    bus.req_a     = ~a;
    bus.req_b     = ~b;
    bus.req_addr  = ~addr;
    bus.p_in      = ~p;
    lat  = 1;
    d_c1 = alu_d;
    while (!bus.done && !bus.mem_err && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    bus.req_valid = 1'b0;
    err      = bus.mem_err;
    func_end = alu_func;
    check_eq("op_cycle_budget", {31'b0, lat < 200}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic       err;
    logic [3:0] fend;
    logic       d1;
    int         dn;

    nRESET        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_func  = '0;
    bus.req_rmw   = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_addr  = '0;
    bus.p_in      = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    #12;
    check_eq("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check_eq("rst_done",      {31'b0, bus.done},      32'd0);
    check_eq("rst_mem_rd",    {31'b0, bus.mem_rd},    32'd0);
    check_eq("rst_mem_wr",    {31'b0, bus.mem_wr},    32'd0);
    check_eq("rst_mem_err",   {31'b0, bus.mem_err},   32'd0);
    check_eq("rst_result",    {24'b0, bus.result},    32'd0);
    check_eq("rst_p_out",     {24'b0, bus.p_out},     32'd0);
    check_eq("rst_alu_func",  {28'b0, alu_func},      32'd0);
    @(negedge clk);
    @(negedge clk);
    nRESET = 1'b1;

    // Register ADD with signed overflow
    run_op(ALU_ADD, 1'b0, 8'h50, 8'h50, 16'h0000, 8'h00, 0, lat, err, fend, d1);
    check_eq("add_latency",  lat,                   32'd2);
    check_eq("add_result",   {24'b0, bus.result},   32'hA0);
    check_eq("add_p_out",    {24'b0, bus.p_out},    32'hC0);
    check_eq("add_func_held", {28'b0, fend},        {28'b0, ALU_ADD});
    @(negedge clk);
    check_eq("add_done_one_cycle", {31'b0, bus.done},      32'd0);
    check_eq("add_ready_after",    {31'b0, bus.req_ready}, 32'd1);

    // RMW INC 0xFF -> 0x00; INC never touches C
    mem[8'h70] = 8'hFF;
    run_op(ALU_INC, 1'b1, 8'h00, 8'h00, 16'h0070, 8'h80, 0, lat, err, fend, d1);
    check_eq("inc_latency",  lat,                 32'd4);
    check_eq("inc_rd_addr",  {16'b0, rd_addr},    32'h0070);
    check_eq("inc_n_wr",     n_wr,                32'd2);
    check_eq("inc_wr0",      {8'b0, wr_addr[0], wr_data[0]}, 32'h0070FF);
    check_eq("inc_wr1",      {8'b0, wr_addr[1], wr_data[1]}, 32'h007000);
    check_eq("inc_result",   {24'b0, bus.result}, 32'h00);
    check_eq("inc_p_out",    {24'b0, bus.p_out},  32'h02);

    // RMW ROL with D set: the ALU must see D=0 on the bus phases
    mem[8'h23] = 8'h80;
    run_op(ALU_ROL, 1'b1, 8'h00, 8'h00, 16'h0123, 8'h09, 0, lat, err, fend, d1);
    check_eq("rol_latency",  lat,                  32'd4);
    check_eq("rol_alu_d",    {31'b0, d_in_bus},    32'd0);
    check_eq("rol_wr0",      {8'b0, wr_addr[0], wr_data[0]}, 32'h012380);
    check_eq("rol_wr1",      {8'b0, wr_addr[1], wr_data[1]}, 32'h012301);
    check_eq("rol_result",   {24'b0, bus.result},  32'h01);
    check_eq("rol_p_out",    {24'b0, bus.p_out},   32'h09);

    // Decimal SUB on a register op passes D and C through to the ALU
    run_op(ALU_SUB, 1'b0, 8'h10, 8'h01, 16'h0000, 8'h09, 0, lat, err, fend, d1);
    check_eq("dsub_latency", lat,                  32'd2);
    check_eq("dsub_alu_d",   {31'b0, d1},          32'd1);
    check_eq("dsub_result",  {24'b0, bus.result},  32'h09);
    check_eq("dsub_p_out",   {24'b0, bus.p_out},   32'h09);

    // EOR to zero keeps V and C, sets Z
    run_op(ALU_EOR, 1'b0, 8'hFF, 8'hFF, 16'h0000, 8'h41, 0, lat, err, fend, d1);
    check_eq("eor_result",   {24'b0, bus.result},  32'h00);
    check_eq("eor_p_out",    {24'b0, bus.p_out},   32'h43);

    // mem_rdy lands on the cycle the wait counter reaches WAIT_MAX, for all three accesses
    mem[8'h10] = 8'h01;
    run_op(ALU_DEC, 1'b1, 8'h00, 8'h00, 16'h0010, 8'h00, WAIT_MAX, lat, err, fend, d1);
    check_eq("edge_latency", lat,                  32'd49);
    check_eq("edge_no_err",  {31'b0, err},         32'd0);
    check_eq("edge_n_wr",    n_wr,                 32'd2);
    check_eq("edge_wr1",     {8'b0, wr_addr[1], wr_data[1]}, 32'h001000);
    check_eq("edge_p_out",   {24'b0, bus.p_out},   32'h02);

    // mem_rdy never comes: timeout in RD
    run_op(ALU_INC, 1'b1, 8'h00, 8'h00, 16'h0020, 8'hFF, 1000, lat, err, fend, d1);
    check_eq("to_err",       {31'b0, err},         32'd1);
    check_eq("to_latency",   lat,                  32'd17);
    check_eq("to_ready",     {31'b0, bus.req_ready}, 32'd1);
    check_eq("to_mem_rd",    {31'b0, bus.mem_rd},  32'd0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done || bus.mem_err) dn++;
    end
    check_eq("to_no_done",   dn,                   32'd0);
    check_eq("to_result_kept", {24'b0, bus.result}, 32'h00);
    check_eq("to_p_out_kept",  {24'b0, bus.p_out},  32'h02);
    check_eq("to_n_wr",      n_wr,                 32'd0);

    // mem_rdy one cycle after the counter limit is too late
    run_op(ALU_INC, 1'b1, 8'h00, 8'h00, 16'h0020, 8'h00, WAIT_MAX + 1, lat, err, fend, d1);
    check_eq("late_err",     {31'b0, err},         32'd1);
    check_eq("late_latency", lat,                  32'd17);

    // Async reset while the dummy write is pending
    ws_cfg = 3;
    n_wr   = 0;
    mem[8'h44] = 8'h5A;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_func  = ALU_ASL;
    bus.req_rmw   = 1'b1;
    bus.req_addr  = 16'h0044;
    bus.p_in      = 8'h00;
    @(negedge clk);
    bus.req_valid = 1'b0;
    dn = 0;
    while (!bus.mem_wr && dn < 50) begin
      @(negedge clk);
      dn++;
    end
    check_eq("rst_mid_dummy_reached", {31'b0, bus.mem_wr}, 32'd1);
    #2 nRESET = 1'b0;
    #1;
    check_eq("rst_mid_mem_wr",    {31'b0, bus.mem_wr},    32'd0);
    check_eq("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check_eq("rst_mid_no_write",  n_wr,                   32'd0);
    @(negedge clk);
    nRESET = 1'b1;
    check_eq("rst_mid_mem_kept",  {24'b0, mem[8'h44]},    32'h5A);

    run_op(ALU_AND, 1'b0, 8'hF0, 8'h3C, 16'h0000, 8'h83, 0, lat, err, fend, d1);
    check_eq("post_rst_latency", lat,                 32'd2);
    check_eq("post_rst_result",  {24'b0, bus.result}, 32'h30);
    check_eq("post_rst_p_out",   {24'b0, bus.p_out},  32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
